// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and counter sizing for div_sched
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int DIV_W = 8;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/div_core.sv
// div_core: restoring divider datapath, one shift-subtract step per step strobe
module div_core #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] q,
  output logic [W-1:0] r
);
  logic [W-1:0] r_rem, r_quo, r_b;
  logic [W:0]   w_sh;
  logic         w_ge;
  logic [W-1:0] w_rem_n, w_quo_n;
  // The shifted remainder needs one extra bit so the compare against b never overflows.
  assign w_sh    = {r_rem, r_quo[W-1]};
  assign w_ge    = w_sh >= {1'b0, r_b};
  assign w_rem_n = W'(w_ge ? w_sh - {1'b0, r_b} : w_sh);
  assign w_quo_n = {r_quo[W-2:0], w_ge};
  // q/r show the values the next step produces, so the scheduler can capture the final result on the last step edge.
  assign q = w_quo_n;
  assign r = w_rem_n;
  // Operand load on acceptance, then one iteration per step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_b   <= '0;
    end else if (load) begin
      r_rem <= '0;
      r_quo <= a;
      r_b   <= b;
    end else if (step) begin
      r_rem <= w_rem_n;
      r_quo <= w_quo_n;
    end
  end
endmodule

// File: rtl/div_sched.sv
// div_sched: round-robin scheduler sharing one sequential divider among N requesters (option: DIV_ZERO_BYPASS_EN)
module div_sched
  import div_pkg::*;
#(
  parameter int N = 4,
  parameter int W = DIV_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_a,
  input  logic [N*W-1:0]       req_b,
  output logic [N-1:0]         req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [$clog2(N)-1:0] rsp_id,
  output logic [W-1:0]         rsp_q,
  output logic [W-1:0]         rsp_r,
  output logic                 rsp_err,
  output logic                 busy
);
  localparam int IW = $clog2(N);
  localparam int CW = cnt_w(W);
  state_t        r_state, w_nxt;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_last, w_id;
  logic          w_any, w_acc, w_last, w_zero;
  logic [W-1:0]  w_a, w_b, w_q, w_r;
  // Round-robin search starting just after the previous winner.
  always_comb begin
    w_any = 1'b0;
    w_id  = '0;
    for (int k = 1; k <= N; k++)
      if (!w_any && req_valid[IW'((int'(r_last) + k) % N)]) begin
        w_any = 1'b1;
        w_id  = IW'((int'(r_last) + k) % N);
      end
  end
  assign w_acc     = r_state == IDLE && w_any;
  assign req_ready = (rst && w_acc) ? N'(1) << w_id : '0;
  assign w_a       = req_a[int'(w_id)*W +: W];
  assign w_b       = req_b[int'(w_id)*W +: W];
  assign w_last    = r_state == CALC && r_cnt == CW'(W - 1);
  assign rsp_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
`ifdef DIV_ZERO_BYPASS_EN
  assign w_zero = w_b == '0;
`else
  assign w_zero = 1'b0;
`endif
  div_core #(.W(W)) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (w_acc),
    .step (r_state == CALC),
    .a    (w_a),
    .b    (w_b),
    .q    (w_q),
    .r    (w_r)
  );
  // Next-state selection.
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    w_nxt = w_acc ? (w_zero ? DONE : CALC) : IDLE;
      CALC:    w_nxt = w_last ? DONE : CALC;
      DONE:    w_nxt = rsp_ready ? IDLE : DONE;
      default: w_nxt = IDLE;
    endcase
  end
  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nxt;
  end
  // Iteration counter and round-robin pointer; r_last also identifies the job in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_last <= IW'(N - 1);
    end else if (w_acc) begin
      r_cnt  <= '0;
      r_last <= w_id;
    end else if (r_state == CALC) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end
  // Response capture on entry to DONE, held until the next entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_id  <= '0;
      rsp_q   <= '0;
      rsp_r   <= '0;
      rsp_err <= 1'b0;
    end else if (w_last) begin
      rsp_id  <= r_last;
      rsp_q   <= w_q;
      rsp_r   <= w_r;
      rsp_err <= 1'b0;
    end else if (w_acc && w_zero) begin
      rsp_id  <= w_id;
      rsp_q   <= '1;
      rsp_r   <= w_a;
      rsp_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: randomized self-checking bench for div_sched against a transaction-level model
module tb_div_sched;
  localparam int N = 4;
  localparam int W = 8;
  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   vld;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid, rsp_ready, rsp_err, busy;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_q, rsp_r;
  logic [W-1:0]   av [N];
  logic [W-1:0]   bv [N];
  int             n_chk = 0;
  int             n_err = 0;
  int             m_last = N - 1;
  always #5 clk = ~clk;
  always_comb
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = av[i];
      req_b[i*W +: W] = bv[i];
    end
  div_sched #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (vld),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q),
    .rsp_r     (rsp_r),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  function automatic int rr(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction
  task automatic txn(input int hold);
    int w, lat;
    logic [W-1:0] a, b, eq, er;
    logic ez;
    #1;
    w = rr(m_last, vld);
    if (w < 0) return;
    chk("gnt", req_ready, 32'(1) << w);
    a  = av[w];
    b  = bv[w];
    ez = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
    ez = b == 0;
`endif
    eq = b == 0 ? 8'hff : a / b;
    er = b == 0 ? a : a % b;
    @(posedge clk);
    m_last = w;
    @(negedge clk);
    chk("busy", busy, 1);
    chk("rdy_busy", req_ready, 0);
    lat = 0;
    while (!rsp_valid && lat < W + 5) begin
      @(negedge clk);
      lat++;
    end
    chk("lat", lat, ez ? 0 : W);
    chk("id", rsp_id, w);
    chk("q", rsp_q, eq);
    chk("r", rsp_r, er);
    chk("err", rsp_err, ez);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_v", rsp_valid, 1);
      chk("hold_q", rsp_q, eq);
      chk("hold_r", rsp_r, er);
      chk("hold_rdy", req_ready, 0);
      chk("hold_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 chk("idle", busy, 0);
  endtask
  task automatic one(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    vld   = N'(1) << i;
    av[i] = a;
    bv[i] = b;
    txn(hold);
  endtask
  task automatic chk_reset_outputs();
    chk("rst_rdy", req_ready, 0);
    chk("rst_v", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_q", rsp_q, 0);
    chk("rst_r", rsp_r, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b0;
    vld = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      av[i] = '0;
      bv[i] = '0;
    end
    repeat (2) @(negedge clk);
    vld = '1;
    #1 chk_reset_outputs();
    vld = '0;
    rst = 1'b1;
    @(negedge clk);
    one(0, 100, 7, 0);
    vld = '1;
    for (int i = 0; i < N; i++) begin
      av[i] = W'($urandom);
      bv[i] = W'($urandom_range(1, 255));
    end
    repeat (5) txn(0);
    one(2, 77, 5, 5);
    one(1, 255, 1, 0);
    one(3, 3, 200, 0);
    one(0, 255, 255, 0);
    one(2, 9, 0, 2);
    for (int t = 0; t < 30; t++) begin
      vld = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        av[i] = W'($urandom);
        bv[i] = ($urandom % 8 == 0) ? '0 : W'($urandom);
      end
      txn($urandom_range(0, 3));
    end
    one(1, 255, 1, 0);
    vld   = 4'b0001;
    av[0] = 200;
    bv[0] = 3;
    #1 chk("mid_gnt", req_ready, 4'b0001);
    @(posedge clk);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    vld = '1;
    #1 chk_reset_outputs();
    @(negedge clk);
    rst = 1'b1;
    m_last = N - 1;
    txn(0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
